pipelined_interval_subtractor: RTL and testbench

- Segmented, fully pipelined WIDTH-bit subtractor for the measure unit: computes diff = a - b, e.g. stop timestamp minus start timestamp to get an interval.
- Borrow ripples one SEG_W-bit segment per cycle. Accepts one operation per cycle.
- Valid/ready handshake on both sides so it can sit between the timestamp capture logic and the result FIFO.

---
 rtl/measure_pkg.sv | 11 +
 rtl/sub_segment_stage.sv | 23 ++
 rtl/pipelined_interval_subtractor.sv | 126 ++++++++++++
 tb/tb_pipelined_interval_subtractor.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/measure_pkg.sv
// Shared defaults and helpers for the measure unit datapath.
package measure_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SEG_W = 16;

  function automatic int seg_count(input int width, input int seg_w);
    return width / seg_w;
  endfunction

endpackage

// File: rtl/sub_segment_stage.sv
// One SEG_W-bit slice of a - b - borrow_in; purely combinational, no latency, no flow control.
module sub_segment_stage
  import measure_pkg::*;
#(
  parameter int SEG_W = DEF_SEG_W
) (
  input  logic [SEG_W-1:0] a_seg,
  input  logic [SEG_W-1:0] b_seg,
  input  logic             borrow_in,
  output logic [SEG_W-1:0] diff_seg,
  output logic             borrow_out,
  output logic             zero_seg
);

  logic [SEG_W:0] full_dat;

  // The extra top bit goes negative exactly when the slice needs to borrow.
  assign full_dat   = {1'b0, a_seg} - {1'b0, b_seg} - {{SEG_W{1'b0}}, borrow_in};
  assign diff_seg   = full_dat[SEG_W-1:0];
  assign borrow_out = full_dat[SEG_W];
  assign zero_seg   = (full_dat[SEG_W-1:0] == '0);

endmodule

// File: rtl/pipelined_interval_subtractor.sv
// Segmented a - b, borrow rippling one segment per stage; latency NSEG cycles, one op per cycle.
// Backpressure freezes the whole pipe while the output is held; ready_o = !(valid_o && !ready_i).
module pipelined_interval_subtractor
  import measure_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG_W = DEF_SEG_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int NSEG = seg_count(WIDTH, SEG_W);

  // Operand remainders are kept right-aligned so each stage always reads its
  // segment from the bottom bits; consumed bits shift out as zeros.
  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero_acc;
    logic             a_msb;
    logic             b_msb;
    logic [WIDTH-1:0] rem_a;
    logic [WIDTH-1:0] rem_b;
  } stage_t;

  stage_t st_q   [NSEG];
  stage_t st_in  [NSEG];
  stage_t st_nxt [NSEG];

  logic [NSEG-1:0][SEG_W-1:0] seg_diff_dat;
  logic [NSEG-1:0]            seg_borrow;
  logic [NSEG-1:0]            seg_zero;

  logic stall;
  logic ovf_q;
  logic ovf_nxt;

  assign valid_o  = st_q[NSEG-1].vld;
  assign stall    = valid_o && !ready_i;
  assign ready_o  = !stall;
  assign diff_o   = st_q[NSEG-1].diff;
  assign borrow_o = st_q[NSEG-1].borrow;
  assign zero_o   = st_q[NSEG-1].zero_acc;
  assign ovf_o    = ovf_q;

  always_comb begin
    for (int k = 0; k < NSEG; k++) begin
      if (k == 0) begin
        st_in[k]          = '0;
        st_in[k].vld      = valid_i;
        st_in[k].zero_acc = 1'b1;
        st_in[k].a_msb    = a_i[WIDTH-1];
        st_in[k].b_msb    = b_i[WIDTH-1];
        st_in[k].rem_a    = a_i;
        st_in[k].rem_b    = b_i;
      end else begin
        st_in[k] = st_q[k-1];
      end
    end
  end

  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    sub_segment_stage #(
      .SEG_W (SEG_W)
    ) u_seg (
      .a_seg      (st_in[g].rem_a[SEG_W-1:0]),
      .b_seg      (st_in[g].rem_b[SEG_W-1:0]),
      .borrow_in  (st_in[g].borrow),
      .diff_seg   (seg_diff_dat[g]),
      .borrow_out (seg_borrow[g]),
      .zero_seg   (seg_zero[g])
    );
  end

  always_comb begin
    for (int k = 0; k < NSEG; k++) begin
      st_nxt[k]                        = st_in[k];
      st_nxt[k].diff[k*SEG_W +: SEG_W] = seg_diff_dat[k];
      st_nxt[k].borrow                 = seg_borrow[k];
      st_nxt[k].zero_acc               = st_in[k].zero_acc & seg_zero[k];
      st_nxt[k].rem_a                  = st_in[k].rem_a >> SEG_W;
      st_nxt[k].rem_b                  = st_in[k].rem_b >> SEG_W;
    end
  end

  assign ovf_nxt = (st_in[NSEG-1].a_msb != st_in[NSEG-1].b_msb) &&
                   (st_nxt[NSEG-1].diff[WIDTH-1] != st_in[NSEG-1].a_msb);

  // Data fields only load behind a valid bit, so the outputs hold while idle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < NSEG; k++) begin
        st_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < NSEG; k++) begin
        if (st_in[k].vld) begin
          st_q[k] <= st_nxt[k];
        end else begin
          st_q[k].vld <= 1'b0;
        end
      end
      if (st_in[NSEG-1].vld) begin
        ovf_q <= ovf_nxt;
      end
    end
  end

  logic unused_tail;
  assign unused_tail = ^{st_q[NSEG-1].rem_a, st_q[NSEG-1].rem_b,
                         st_q[NSEG-1].a_msb, st_q[NSEG-1].b_msb};

endmodule

// File: tb/tb_pipelined_interval_subtractor.sv
// Directed plus random checks of the segmented subtractor against an arithmetic reference model.
module tb_pipelined_interval_subtractor;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] diff_o;
  logic        borrow_o;
  logic        ovf_o;
  logic        zero_o;

  pipelined_interval_subtractor #(
    .WIDTH (32),
    .SEG_W (16)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .a_i      (a_i),
    .b_i      (b_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .diff_o   (diff_o),
    .borrow_o (borrow_o),
    .ovf_o    (ovf_o),
    .zero_o   (zero_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] diff;
    logic        borrow;
    logic        ovf;
    logic        zero;
  } res_t;

  res_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
    res_t   r;
    longint sd;
    r.diff   = a - b;
    r.borrow = (a < b);
    sd       = longint'($signed(a)) - longint'($signed(b));
    r.ovf    = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    r.zero   = (r.diff == 32'd0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic chk_res(input string tag, input res_t r);
    chk({tag, "_diff"},   diff_o,   r.diff);
    chk({tag, "_borrow"}, {31'd0, borrow_o}, {31'd0, r.borrow});
    chk({tag, "_ovf"},    {31'd0, ovf_o},    {31'd0, r.ovf});
    chk({tag, "_zero"},   {31'd0, zero_o},   {31'd0, r.zero});
  endtask

  // Inputs are already applied; settle, score both handshakes, then advance one edge.
  task automatic cyc();
    logic in_x;
    logic out_x;
    res_t e;
    #1;
    in_x  = valid_i && ready_o && rst_ni;
    out_x = valid_o && ready_i && rst_ni;
    if (out_x) begin
      n_chk++;
      assert (q.size() != 0) else begin
        n_fail++;
        $error("FAIL spurious_output: observed result 0x%08h expected none pending", diff_o);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk_res("stream", e);
      end
    end
    if (in_x) q.push_back(model(a_i, b_i));
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_one(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ed, input logic eb, input logic eo, input logic ez);
    valid_i = 1'b1;
    a_i     = a;
    b_i     = b;
    cyc();
    valid_i = 1'b0;
    chk("lat_not_yet", {31'd0, valid_o}, 32'd0);
    cyc();
    chk("lat_valid", {31'd0, valid_o}, 32'd1);
    chk("dir_diff",  diff_o, ed);
    chk("dir_borrow", {31'd0, borrow_o}, {31'd0, eb});
    chk("dir_ovf",    {31'd0, ovf_o},    {31'd0, eo});
    chk("dir_zero",   {31'd0, zero_o},   {31'd0, ez});
    cyc();
  endtask

  task automatic drain();
    for (int t = 0; t < 20 && q.size() != 0; t++) cyc();
    chk("drain_pending", q.size(), 32'd0);
  endtask

  initial begin
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    a_i     = '0;
    b_i     = '0;
    cyc();
    cyc();
    chk("rst_valid_o", {31'd0, valid_o}, 32'd0);
    chk("rst_diff_o",  diff_o, 32'd0);
    chk("rst_flags",   {29'd0, borrow_o, ovf_o, zero_o}, 32'd0);
    chk("rst_ready_o", {31'd0, ready_o}, 32'd1);
    rst_ni = 1'b1;
    cyc();

    // Directed boundary cases.
    send_one(32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
    send_one(32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    send_one(32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    send_one(32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    send_one(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0);

    // Back-to-back random stream at full rate.
    for (int i = 0; i < 8; i++) begin
      valid_i = 1'b1;
      a_i     = $urandom;
      b_i     = (i == 3) ? a_i : $urandom;
      if (i == 5) b_i = {16'h0000, a_i[15:0] + 16'd1};
      cyc();
      chk("tput_ready_o", {31'd0, ready_o}, 32'd1);
      if (i >= 1) chk("tput_valid_o", {31'd0, valid_o}, 32'd1);
    end
    valid_i = 1'b0;
    cyc();
    chk("tput_last_valid", {31'd0, valid_o}, 32'd1);
    cyc();
    chk("tput_idle", {31'd0, valid_o}, 32'd0);
    drain();

    // Backpressure with two operations in flight and a third held by the sender.
    valid_i = 1'b1;
    a_i = $urandom; b_i = $urandom;
    cyc();
    a_i = $urandom; b_i = $urandom;
    cyc();
    ready_i = 1'b0;
    a_i = $urandom; b_i = $urandom;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_ready_o", {31'd0, ready_o}, 32'd0);
      chk("stall_valid_o", {31'd0, valid_o}, 32'd1);
      chk("stall_diff_o",  diff_o, q[0].diff);
    end
    ready_i = 1'b1;
    cyc();
    valid_i = 1'b0;
    drain();

    // Reset with two operations in flight.
    valid_i = 1'b1;
    a_i = $urandom; b_i = $urandom;
    cyc();
    a_i = $urandom; b_i = $urandom;
    cyc();
    valid_i = 1'b0;
    ready_i = 1'b0;
    rst_ni  = 1'b0;
    cyc();
    q.delete();
    chk("mid_rst_valid_o", {31'd0, valid_o}, 32'd0);
    chk("mid_rst_diff_o",  diff_o, 32'd0);
    chk("mid_rst_ready_o", {31'd0, ready_o}, 32'd1);
    rst_ni  = 1'b1;
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("no_stale_valid_o", {31'd0, valid_o}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
